fifo8x9_ctrl: RTL and testbench

Sequencing controller for the 8-entry, 9-bit FIFO datapath. It arbitrates two write requesters round-robin and serves one read consumer through valid/ready handshakes. It tracks occupancy and full/empty, and drives the datapath strobes (`wren`, `WrInc`, `WrPtrClr`, `rden`, `RdInc`, `RdPtrClr`). It sits between the producers/consumer and the datapath and owns all pointer management; the datapath pointers have no reset of their own.

---
 rtl/fifo8x9_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_fifo8x9_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo8x9_ctrl.sv
// -----------------------------------------------------------------------------
// fifo8x9_ctrl
//
// Sequencing controller for an 8-entry, 9-bit FIFO datapath. It arbitrates two
// write requesters round-robin, serves one read consumer and owns all pointer
// management. It keeps shadow copies of the datapath pointers, because the
// datapath pointers have no reset of their own. It also tracks occupancy.
//
// Optional feature: define FIFO8X9_CTRL_ERR_EN to add the sticky error outputs
// ovf_err and udf_err. With the macro undefined, those ports and their logic
// are absent.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous reset, active low
//   flush        in   synchronous request to empty the FIFO
//   wr_req[1:0]  in   write requests, requester 0 / 1
//   wr_data0/1   in   9-bit write data per requester
//   wr_gnt[1:0]  out  one-hot write grant (write accepted when req & gnt)
//   rd_req       in   consumer pop request
//   rd_ack       out  pop accepted this cycle
//   dout_valid   out  datapath DataOut valid (one cycle after rd_ack)
//   DataIn       out  write data of the granted requester
//   wren, WrInc, WrPtrClr, rden, RdInc, RdPtrClr  out  datapath strobes
//   count        out  occupancy 0..8
//   full, empty  out  occupancy flags
//   ovf_err      out  (FIFO8X9_CTRL_ERR_EN) sticky: write requested while full
//   udf_err      out  (FIFO8X9_CTRL_ERR_EN) sticky: read requested while empty
// -----------------------------------------------------------------------------
module fifo8x9_ctrl #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [1:0]       wr_req,
  input  logic [8:0]       wr_data0,
  input  logic [8:0]       wr_data1,
  output logic [1:0]       wr_gnt,
  input  logic             rd_req,
  output logic             rd_ack,
  output logic             dout_valid,
  output logic [8:0]       DataIn,
  output logic             wren,
  output logic             WrInc,
  output logic             WrPtrClr,
  output logic             rden,
  output logic             RdInc,
  output logic             RdPtrClr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
`ifdef FIFO8X9_CTRL_ERR_EN
  ,
  output logic             ovf_err,
  output logic             udf_err
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             last_q, last_d;      // index of the most recently granted requester
  logic             dout_valid_q;

  logic [1:0]       wr_sel;
  logic             wr_acc;
  logic             rd_acc;

  assign full       = (count_q == CNT_MAX);
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign dout_valid = dout_valid_q;

  // Next-state and output logic
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    wr_sel   = 2'b00;
    wr_acc   = 1'b0;
    rd_acc   = 1'b0;
    wr_gnt   = 2'b00;
    rd_ack   = 1'b0;
    DataIn   = '0;
    wren     = 1'b0;
    WrInc    = 1'b0;
    WrPtrClr = 1'b0;
    rden     = 1'b0;
    RdInc    = 1'b0;
    RdPtrClr = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (flush) begin
          // Flush wins over every request. Nothing is accepted this cycle.
          // Occupancy is zeroed now, so empty is already high during FLUSH.
          state_d  = ST_FLUSH;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
        end else begin
          if (!full) begin
            case (wr_req)
              2'b01:   wr_sel = 2'b01;
              2'b10:   wr_sel = 2'b10;
              // Both requesters pending: the requester not granted last wins.
              2'b11:   wr_sel = last_q ? 2'b01 : 2'b10;
              default: wr_sel = 2'b00;
            endcase
          end
          wr_acc = |wr_sel;
          rd_acc = rd_req & ~empty;
          wr_gnt = wr_sel;
          rd_ack = rd_acc;

          if (wr_acc) begin
            wren   = 1'b1;
            last_d = wr_sel[1];
            DataIn = wr_sel[1] ? wr_data1 : wr_data0;
            // At the last index, clear the datapath pointer instead of incrementing it.
            if (wr_ptr_q == PTR_LAST) begin
              WrPtrClr = 1'b1;
              wr_ptr_d = '0;
            end else begin
              WrInc    = 1'b1;
              wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
          end

          if (rd_acc) begin
            rden = 1'b1;
            if (rd_ptr_q == PTR_LAST) begin
              RdPtrClr = 1'b1;
              rd_ptr_d = '0;
            end else begin
              RdInc    = 1'b1;
              rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
          end

          case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
          endcase
        end
      end

      // INIT, FLUSH and any illegal encoding: clear the datapath pointers for
      // one cycle, then resume normal operation.
      default: begin
        WrPtrClr = 1'b1;
        RdPtrClr = 1'b1;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
        state_d  = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_INIT;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_q       <= 1'b1;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      last_q       <= last_d;
      dout_valid_q <= rd_acc;
    end
  end

`ifdef FIFO8X9_CTRL_ERR_EN
  logic ovf_err_q, ovf_err_d;
  logic udf_err_q, udf_err_d;

  always_comb begin
    ovf_err_d = ovf_err_q;
    udf_err_d = udf_err_q;
    if (state_q == ST_RUN) begin
      if (flush) begin
        ovf_err_d = 1'b0;
        udf_err_d = 1'b0;
      end else begin
        if (full && (|wr_req)) ovf_err_d = 1'b1;
        if (empty && rd_req)   udf_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_err_q <= 1'b0;
      udf_err_q <= 1'b0;
    end else begin
      ovf_err_q <= ovf_err_d;
      udf_err_q <= udf_err_d;
    end
  end

  assign ovf_err = ovf_err_q;
  assign udf_err = udf_err_q;
`endif

endmodule

// File: tb/tb_fifo8x9_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo8x9_ctrl
//
// Directed bench for fifo8x9_ctrl. A small behavioural datapath (8x9 memory,
// pointers without reset, clear over increment, registered read) is driven by
// the controller strobes. Read data therefore exposes any strobe error.
// Define FIFO8X9_CTRL_ERR_EN to also check the sticky error outputs.
// -----------------------------------------------------------------------------
module tb_fifo8x9_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [1:0] wr_req;
  logic [8:0] wr_data0, wr_data1;
  logic [1:0] wr_gnt;
  logic       rd_req, rd_ack, dout_valid;
  logic [8:0] DataIn;
  logic       wren, WrInc, WrPtrClr, rden, RdInc, RdPtrClr;
  logic [3:0] count;
  logic       full, empty;
`ifdef FIFO8X9_CTRL_ERR_EN
  logic       ovf_err, udf_err;
`endif

  always #5 clk = ~clk;

  fifo8x9_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_req(wr_req), .wr_data0(wr_data0), .wr_data1(wr_data1),
    .wr_gnt(wr_gnt), .rd_req(rd_req), .rd_ack(rd_ack), .dout_valid(dout_valid),
    .DataIn(DataIn), .wren(wren), .WrInc(WrInc), .WrPtrClr(WrPtrClr),
    .rden(rden), .RdInc(RdInc), .RdPtrClr(RdPtrClr),
    .count(count), .full(full), .empty(empty)
`ifdef FIFO8X9_CTRL_ERR_EN
    , .ovf_err(ovf_err), .udf_err(udf_err)
`endif
  );

  // Behavioural datapath. Its pointers start at junk values on purpose.
  logic [8:0] dp_mem [8];
  logic [2:0] dp_wp = 3'd5;
  logic [2:0] dp_rp = 3'd2;
  logic [8:0] dp_dout = 9'h000;

  always @(posedge clk) begin
    if (wren) dp_mem[dp_wp] <= DataIn;
    if (WrPtrClr)   dp_wp <= 3'd0;
    else if (WrInc) dp_wp <= dp_wp + 3'd1;
    if (rden) dp_dout <= dp_mem[dp_rp];
    if (RdPtrClr)   dp_rp <= 3'd0;
    else if (RdInc) dp_rp <= dp_rp + 3'd1;
  end

  int tests_run = 0;
  int tests_failed = 0;
  logic [8:0] exp_q [$];
  int wr_idx = 0;
  int rd_idx = 0;

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle. Called at posedge+1 and returns at the next posedge+1.
  // eg/ea are the hand-derived grant and ack expected for this cycle.
  task automatic cyc(input logic [1:0] wr, input logic rd, input logic fl,
                     input logic [8:0] d0, input logic [8:0] d1,
                     input logic [1:0] eg, input logic ea);
    logic [8:0] rexp;
    rexp     = 9'h000;
    wr_req   = wr;
    rd_req   = rd;
    flush    = fl;
    wr_data0 = d0;
    wr_data1 = d1;
    #3;
    check("wr_gnt", wr_gnt, eg);
    check("rd_ack", rd_ack, ea);
    check("wren", wren, |eg);
    check("rden", rden, ea);
    if (eg != 2'b00) begin
      check("DataIn", DataIn, eg[1] ? d1 : d0);
      check("WrPtrClr", WrPtrClr, wr_idx == 7);
      check("WrInc", WrInc, wr_idx != 7);
      exp_q.push_back(eg[1] ? d1 : d0);
      wr_idx = (wr_idx + 1) % 8;
    end
    if (ea) begin
      check("RdPtrClr", RdPtrClr, rd_idx == 7);
      check("RdInc", RdInc, rd_idx != 7);
      if (exp_q.size() > 0) rexp = exp_q.pop_front();
      rd_idx = (rd_idx + 1) % 8;
    end
    @(posedge clk);
    #1;
    check("dout_valid", dout_valid, ea);
    if (ea) check("DataOut", dp_dout, rexp);
    $display("[TB] wr=%b rd=%b fl=%b gnt=%b ack=%b count=%0d", wr, rd, fl, wr_gnt, rd_ack, count);
    wr_req = 2'b00;
    rd_req = 1'b0;
    flush  = 1'b0;
    if (fl) begin
      exp_q.delete();
      wr_idx = 0;
      rd_idx = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; flush = 1'b0; wr_req = 2'b11; rd_req = 1'b1;
    wr_data0 = 9'h1AA; wr_data1 = 9'h155;
    repeat (2) @(posedge clk);
    #1;
    // Reset values, with requests active
    check("rst_gnt", wr_gnt, 0);
    check("rst_ack", rd_ack, 0);
    check("rst_dvalid", dout_valid, 0);
    check("rst_wren", wren, 0);
    check("rst_rden", rden, 0);
    check("rst_wrinc", WrInc, 0);
    check("rst_rdinc", RdInc, 0);
    check("rst_datain", DataIn, 0);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_wrclr", WrPtrClr, 1);
    check("rst_rdclr", RdPtrClr, 1);

    // INIT cycle
    rst = 1'b1;
    #3;
    check("init_gnt", wr_gnt, 0);
    check("init_ack", rd_ack, 0);
    check("init_wrclr", WrPtrClr, 1);
    check("init_rdclr", RdPtrClr, 1);
    @(posedge clk);
    #1;
    wr_req = 2'b00; rd_req = 1'b0;
    check("run_empty", empty, 1);
    check("run_count", count, 0);

    // Arbitration: both requesting, requester 0 first
    cyc(2'b11, 1'b0, 1'b0, 9'h100, 9'h1F0, 2'b01, 1'b0);
    cyc(2'b11, 1'b0, 1'b0, 9'h1F1, 9'h101, 2'b10, 1'b0);
    cyc(2'b11, 1'b0, 1'b0, 9'h102, 9'h1F2, 2'b01, 1'b0);
    cyc(2'b11, 1'b0, 1'b0, 9'h1F3, 9'h103, 2'b10, 1'b0);
    check("arb_count", count, 4);

    // Fill to 8; the 8th write wraps the pointer
    for (int i = 4; i < 8; i++)
      cyc(2'b10, 1'b0, 1'b0, 9'h000, 9'(9'h100 + i), 2'b10, 1'b0);
    check("full_count", count, 8);
    check("full_flag", full, 1);
    check("full_empty", empty, 0);
    cyc(2'b11, 1'b0, 1'b0, 9'h111, 9'h122, 2'b00, 1'b0);
`ifdef FIFO8X9_CTRL_ERR_EN
    check("ovf_set", ovf_err, 1);
    check("udf_clear", udf_err, 0);
`endif

    // Drain 8 in order
    for (int i = 0; i < 8; i++)
      cyc(2'b00, 1'b1, 1'b0, 9'h000, 9'h000, 2'b00, 1'b1);
    check("drain_count", count, 0);
    check("drain_empty", empty, 1);
    check("drain_full", full, 0);
    cyc(2'b00, 1'b1, 1'b0, 9'h000, 9'h000, 2'b00, 1'b0);
`ifdef FIFO8X9_CTRL_ERR_EN
    check("udf_set", udf_err, 1);
`endif

    // Simultaneous write and read at count 3
    for (int i = 0; i < 3; i++)
      cyc(2'b01, 1'b0, 1'b0, 9'(9'h010 + i), 9'h000, 2'b01, 1'b0);
    check("mix_start", count, 3);
    for (int i = 0; i < 20; i++) begin
      logic [1:0] w;
      w = (i % 2 == 1) ? 2'b10 : 2'b01;
      cyc(w, 1'b1, 1'b0, 9'(9'h020 + i), 9'(9'h040 + i), w, 1'b1);
      check("mix_count", count, 3);
    end

    // Flush at count 5, preceded by a read
    for (int i = 0; i < 3; i++)
      cyc(2'b01, 1'b0, 1'b0, 9'(9'h060 + i), 9'h000, 2'b01, 1'b0);
    cyc(2'b00, 1'b1, 1'b0, 9'h000, 9'h000, 2'b00, 1'b1);
    check("pre_flush_count", count, 5);
`ifdef FIFO8X9_CTRL_ERR_EN
    check("ovf_sticky", ovf_err, 1);
    check("udf_sticky", udf_err, 1);
`endif
    cyc(2'b11, 1'b1, 1'b1, 9'h1AB, 9'h1CD, 2'b00, 1'b0);
    // FLUSH state cycle
    wr_req = 2'b11; rd_req = 1'b1;
    #3;
    check("flush_gnt", wr_gnt, 0);
    check("flush_ack", rd_ack, 0);
    check("flush_wrclr", WrPtrClr, 1);
    check("flush_rdclr", RdPtrClr, 1);
    check("flush_count", count, 0);
    check("flush_empty", empty, 1);
    @(posedge clk);
    #1;
    wr_req = 2'b00; rd_req = 1'b0;
`ifdef FIFO8X9_CTRL_ERR_EN
    check("ovf_flushed", ovf_err, 0);
    check("udf_flushed", udf_err, 0);
`endif
    cyc(2'b01, 1'b0, 1'b0, 9'h155, 9'h000, 2'b01, 1'b0);
    cyc(2'b00, 1'b1, 1'b0, 9'h000, 9'h000, 2'b00, 1'b1);
    check("post_flush_count", count, 0);

    // Asynchronous reset mid-operation
    cyc(2'b01, 1'b0, 1'b0, 9'h0AA, 9'h000, 2'b01, 1'b0);
    check("pre_rst_count", count, 1);
    wr_req = 2'b01;
    rst = 1'b0;
    #1;
    check("arst_count", count, 0);
    check("arst_empty", empty, 1);
    check("arst_gnt", wr_gnt, 0);
    check("arst_wrclr", WrPtrClr, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    wr_req = 2'b00;
    exp_q.delete();
    wr_idx = 0;
    rd_idx = 0;
    // Last-granted register is back to 1, so requester 0 wins first
    cyc(2'b11, 1'b0, 1'b0, 9'h0BB, 9'h0CC, 2'b01, 1'b0);
    cyc(2'b00, 1'b1, 1'b0, 9'h000, 9'h000, 2'b00, 1'b1);
    check("final_empty", empty, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
